// File: rtl/data_mover_pkg.sv
// ============================================================================
// Module      : data_mover_pkg
// Description : Shared widths, command opcodes and FSM state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package data_mover_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // A zero length field stands for the full 64-byte address space.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [ADDR_W-1:0] len);
    return (len == '0) ? CNT_W'(1 << ADDR_W) : {1'b0, len};
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mover.sv
// ============================================================================
// Module      : data_mover
// Description : Byte mover for a 64x8 memory with LOAD/STORE/FILL/COPY ops.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module data_mover
  import data_mover_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_src,
  input  logic [ADDR_W-1:0] i_cmd_dst,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [ADDR_W-1:0] o_data_address,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_write_enable,
  input  logic [DATA_W-1:0] i_read_data
);

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_off;
  logic [DATA_W-1:0] r_rsp;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_busy;
  logic              r_ready;

  op_e               w_op;
  logic [CNT_W-1:0]  w_next_off;
  logic              w_last;
  logic [ADDR_W-1:0] w_cur_dst;
  logic [ADDR_W-1:0] w_nxt_dst;
  logic [ADDR_W-1:0] w_nxt_src;

  assign w_op       = op_e'(i_cmd_op);
  assign w_next_off = r_off + CNT_W'(1);
  assign w_last     = (w_next_off == r_count);
  assign w_cur_dst  = r_dst + ADDR_W'(r_off);
  assign w_nxt_dst  = r_dst + ADDR_W'(w_next_off);
  assign w_nxt_src  = r_src + ADDR_W'(w_next_off);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_off   <= '0;
      r_rsp   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            r_op    <= w_op;
            r_src   <= i_cmd_src;
            r_dst   <= i_cmd_dst;
            r_off   <= '0;
            r_count <= (w_op == OP_FILL || w_op == OP_COPY) ?
                       len_to_count(i_cmd_len) : CNT_W'(1);
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            if (w_op == OP_LOAD || w_op == OP_COPY) begin
              r_state <= ST_RD;
              r_addr  <= i_cmd_src;
            end else begin
              r_state <= ST_WR;
              r_addr  <= i_cmd_dst;
              r_wdata <= i_cmd_data;
              r_we    <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (r_op == OP_LOAD) begin
            r_rsp   <= i_read_data;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            // r_wdata doubles as the COPY byte register.
            r_wdata <= i_read_data;
            r_addr  <= w_cur_dst;
            r_we    <= 1'b1;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (w_last) begin
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_off <= w_next_off;
            if (r_op == OP_FILL) begin
              r_addr <= w_nxt_dst;
            end else begin
              r_addr  <= w_nxt_src;
              r_we    <= 1'b0;
              r_state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready    = r_ready;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_rsp_data     = r_rsp;
  assign o_data_address = r_addr;
  assign o_write_data   = r_wdata;
  // Strobe is masked while reset is asserted so an aborted command cannot write.
  assign o_write_enable = r_we & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_data_mover.sv
// ============================================================================
// Module      : tb_data_mover
// Description : Self-checking bench for data_mover with a 64x8 memory model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mover;
  import data_mover_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_src, cmd_dst, cmd_len;
  logic [7:0] cmd_data;
  logic       busy, done;
  logic [7:0] rsp_data;
  logic [5:0] data_address;
  logic [7:0] write_data;
  logic       write_enable;
  logic [7:0] read_data;

  logic [7:0] mem[64];
  logic [7:0] ref_mem[64];
  logic [7:0] ref_rsp;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  data_mover dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst), .i_cmd_len(cmd_len),
    .i_cmd_data(cmd_data), .o_busy(busy), .o_done(done), .o_rsp_data(rsp_data),
    .o_data_address(data_address), .o_write_data(write_data),
    .o_write_enable(write_enable), .i_read_data(read_data)
  );

  assign read_data = mem[data_address];
  always @(posedge clk) if (write_enable) mem[data_address] <= write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, bad, 0);
  endtask

  // Reference: sequential byte semantics, addresses modulo 64.
  task automatic model_exec(input logic [1:0] op, input logic [5:0] src,
                            input logic [5:0] dst, input logic [5:0] len,
                            input logic [7:0] data, output int lat);
    int n = (len == 0) ? 64 : int'(len);
    case (op)
      2'd0: begin ref_rsp = ref_mem[src]; lat = 2; end
      2'd1: begin ref_mem[dst] = data; lat = 2; end
      2'd2: begin
        for (int i = 0; i < n; i++) ref_mem[(int'(dst) + i) % 64] = data;
        lat = n + 1;
      end
      default: begin
        for (int i = 0; i < n; i++)
          ref_mem[(int'(dst) + i) % 64] = ref_mem[(int'(src) + i) % 64];
        lat = 2 * n + 1;
      end
    endcase
  endtask

  // Entered and left on a negedge; inputs are scrambled right after accept.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                         input logic [5:0] len, input logic [7:0] data, output int cyc);
    int exp_lat;
    bit seen = 0, busy_ok = 1;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_src = 6'($urandom);
    cmd_dst = 6'($urandom); cmd_len = 6'($urandom); cmd_data = 8'($urandom);
    model_exec(op, src, dst, len, data, exp_lat);
    cyc = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk); cyc++;
      if (!busy || cmd_ready) busy_ok = 0;
      if (done) seen = 1;
    end
    check("latency", cyc, exp_lat);
    check("busy_noready", busy_ok, 1);
    check("rsp_data", rsp_data, ref_rsp);
    check_mem("mem_after_cmd");
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] src, dst, len;
    logic [7:0] data;
    int         lat;
    logic [7:0] rsp;
  } vec_t;

  vec_t vt[8];

  initial begin
    int cyc, bad;
    bit seen;
    logic [1:0] rop;
    logic [5:0] rlen;

    vt[0] = '{2'd3, 6'd0,  6'd32, 6'd0, 8'h00, 129, 8'h00};
    vt[1] = '{2'd1, 6'd0,  6'd5,  6'd0, 8'hA5, 2,   8'h00};
    vt[2] = '{2'd0, 6'd5,  6'd0,  6'd0, 8'h00, 2,   8'hA5};
    vt[3] = '{2'd2, 6'd0,  6'd62, 6'd4, 8'h3C, 5,   8'hA5};
    vt[4] = '{2'd0, 6'd63, 6'd0,  6'd0, 8'h00, 2,   8'h3C};
    vt[5] = '{2'd0, 6'd2,  6'd0,  6'd0, 8'h00, 2,   8'h02};
    vt[6] = '{2'd3, 6'd60, 6'd62, 6'd3, 8'h00, 7,   8'h02};
    vt[7] = '{2'd0, 6'd0,  6'd0,  6'd0, 8'h00, 2,   8'h1C};

    for (int i = 0; i < 64; i++) begin mem[i] = 8'(i); ref_mem[i] = 8'(i); end
    ref_rsp = 8'h00;
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0; cmd_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rsp", rsp_data, 0);
    check("rst_addr", data_address, 0);
    check("rst_wdata", write_data, 0);
    check("rst_we", write_enable, 0);
    rst = 0;

    for (int v = 0; v < 8; v++) begin
      run_cmd(vt[v].op, vt[v].src, vt[v].dst, vt[v].len, vt[v].data, cyc);
      check("tbl_latency", cyc, vt[v].lat);
      check("tbl_rsp", rsp_data, vt[v].rsp);
      if (v == 0) begin
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i % 32)) bad++;
        check("copy64_wrap", bad, 0);
      end
      if (v == 3) begin
        check("fill_62", mem[62], 8'h3C);
        check("fill_63", mem[63], 8'h3C);
        check("fill_0", mem[0], 8'h3C);
        check("fill_1", mem[1], 8'h3C);
        check("fill_2_untouched", mem[2], 8'h02);
      end
    end

    // Different command held valid throughout a FILL must be ignored.
    cmd_valid = 1; cmd_op = 2'd2; cmd_dst = 6'd40; cmd_len = 6'd8; cmd_data = 8'h5A;
    @(posedge clk); #1;
    cmd_op = 2'd1; cmd_dst = 6'd20; cmd_data = 8'h77;
    model_exec(2'd2, 6'd0, 6'd40, 6'd8, 8'h5A, bad);
    cyc = 0; seen = 0; bad = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk); cyc++;
      if (cmd_ready) bad++;
      if (done) seen = 1;
    end
    cmd_valid = 0;
    check("held_valid_latency", cyc, 9);
    check("held_valid_ready_low", bad, 0);
    @(negedge clk);
    check("held_valid_not_queued", busy, 0);
    check("held_valid_mem20", mem[20], ref_mem[20]);
    check_mem("held_valid_mem");

    // Reset after three FILL writes aborts the command.
    cmd_valid = 1; cmd_op = 2'd2; cmd_dst = 6'd10; cmd_len = 6'd8; cmd_data = 8'hC3;
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    for (int i = 10; i <= 12; i++) ref_mem[i] = 8'hC3;
    ref_rsp = 8'h00;
    #1 check("we_low_in_rst", write_enable, 0);
    @(posedge clk); #1;
    rst = 0;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (done || write_enable) seen = 1; end
    check("abort_no_done_no_we", seen, 0);
    check_mem("abort_mem");

    for (int r = 0; r < 25; r++) begin
      rop  = 2'($urandom_range(0, 3));
      rlen = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 8)) : 6'($urandom);
      run_cmd(rop, 6'($urandom), 6'($urandom), rlen, 8'($urandom), cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mover.md
DATA_MOVER -- requirements
Module: data_mover

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command; high only in IDLE.
REQ-006 cmd_op  input  2  operation: 00 LOAD, 01 STORE, 10 FILL, 11 COPY.
REQ-007 cmd_src  input  6  source address (LOAD, COPY).
REQ-008 cmd_dst  input  6  destination address (STORE, FILL, COPY).
REQ-009 cmd_len  input  6  byte count (FILL, COPY); 0 encodes 64.
REQ-010 cmd_data  input  8  store/fill byte.
REQ-011 busy  output  1  command in progress (state != IDLE).
REQ-012 done  output  1  one-cycle pulse when a command completes.
REQ-013 rsp_data  output  8  LOAD result; holds its value until the next LOAD completes.
REQ-014 data_address  output  6  memory address.
REQ-015 write_data  output  8  memory write byte.
REQ-016 write_enable  output  1  memory write strobe; the memory writes while it is high.
REQ-017 read_data  input  8  memory read byte, combinational from data_address.

Function
REQ-018 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1. All cmd_* fields SHALL be captured at that edge, and later input changes SHALL be ignored.
REQ-019 The FSM SHALL have four states: IDLE, RD, WR and DONE. DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-020 LOAD SHALL go IDLE->RD->DONE. In RD, data_address=src, and read_data SHALL be registered into rsp_data at the end of RD.
REQ-021 STORE SHALL go IDLE->WR->DONE. In WR, data_address=dst, write_data=cmd_data and write_enable=1 for exactly one cycle.
REQ-022 FILL SHALL spend N consecutive WR cycles (N = len, 0 meaning 64), writing cmd_data to dst, dst+1, ... dst+N-1, then enter DONE.
REQ-023 COPY SHALL alternate RD and WR N times. RD i SHALL drive src+i and latch read_data into an internal byte register. WR i SHALL drive dst+i with that byte. Then the FSM SHALL enter DONE.
REQ-024 Address arithmetic SHALL be modulo 64, so (63+1)=0 with silent wrap.
REQ-025 COPY SHALL proceed in forward order only. With overlapping ranges, each byte SHALL be read immediately before its write, exactly as the sequential order defines.
REQ-026 Latency from the accept edge to done high SHALL be: LOAD 2 cycles, STORE 2 cycles, FILL N+1 cycles, COPY 2N+1 cycles.
REQ-027 data_address, write_data and write_enable SHALL be functions of registered state only, with no combinational path from cmd_* inputs.
REQ-028 write_enable SHALL be 0 in IDLE, RD and DONE, and whenever rst=1.
REQ-029 In IDLE, data_address and write_data SHALL hold their last values.
REQ-030 cmd_valid during busy SHALL be ignored and SHALL NOT be queued.
REQ-031 A new command MAY be accepted in the first IDLE cycle after DONE.

Reset
REQ-032 On rst, at the next edge: state=IDLE, cmd_ready=1, busy=0, done=0, rsp_data=0, data_address=0, write_data=0, write_enable=0.
REQ-033 Reset mid-operation SHALL abort the command without a done pulse. Writes already performed stay in memory, and no further writes SHALL occur.

Structure
REQ-034 A shared package data_mover_pkg SHALL hold ADDR_W=6, DATA_W=8, the op encoding and the state encoding.
REQ-035 The design SHALL be a single module with no sub-module. The offset counter (7 bits, to count to 64) and the byte register SHALL be inline.

Verification
REQ-036 The bench SHALL use a 64x8 behavioural memory model that writes while write_enable=1.
REQ-037 STORE dst=5 data=0xA5, then LOAD src=5 -> mem[5]=0xA5; rsp_data=0xA5; done exactly 2 cycles after each accept.
REQ-038 FILL dst=62 len=4 data=0x3C -> mem[62], mem[63], mem[0], mem[1]=0x3C; mem[2] unchanged; done at accept+5.
REQ-039 COPY src=0 dst=32 len=0, with mem[i]=i -> mem[32+i]=i for i=0..31 and mem[i]=i-32 for i=32..63 (wrapped second half re-reads copied data); done at accept+129.
REQ-040 cmd_valid held high during a FILL len=8 with a different op -> second command ignored until IDLE; cmd_ready=0 throughout busy.
REQ-041 rst asserted on the 3rd WR cycle of FILL dst=10 len=8 -> only mem[10..12] written; no done pulse; write_enable=0 during rst; cmd_ready=1 after the reset edge.
